// File: rtl/key_event_vector.sv
// key_event_vector: debounce N active-low keys, detect press/release/long/repeat
// per channel and serialise all events into one valid/ready stream.
module key_event_vector #(
    parameter int SIGNAL_BIT_WIDTH          = 16,
    parameter int INDEX_BIT_WIDTH           = 4,
    parameter int DEBOUNCE_LENGTH           = 4,
    parameter int DEBOUNCE_LENGTH_BIT_WIDTH = 3,
    parameter int LONGPRESS_LENGTH          = 512,
    parameter int REPEAT_PERIOD             = 64,
    parameter int TIMER_BIT_WIDTH           = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [SIGNAL_BIT_WIDTH-1:0] signals_n,
    output logic [SIGNAL_BIT_WIDTH-1:0] pressed,
    output logic                        event_valid,
    output logic [INDEX_BIT_WIDTH-1:0]  event_index,
    output logic [1:0]                  event_kind,
    input  logic                        event_ready,
    output logic                        overflow
);
    localparam int N         = SIGNAL_BIT_WIDTH;
    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;

    // Arbitration order inside one channel: PRESS, LONG, REPEAT, RELEASE.
    localparam logic [3:0][1:0] KIND_ORDER = {2'd1, 2'd3, 2'd2, 2'd0};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HELD      = 2'd1,
        ST_REPEATING = 2'd2
    } state_t;

    logic [N-1:0][3:0]          w_set;
    logic [N-1:0][3:0]          r_pend;
    logic [N-1:0][3:0]          w_grant;
    logic [N-1:0][3:0]          w_clr;
    logic                       w_any;
    logic                       w_load;
    logic [INDEX_BIT_WIDTH-1:0] w_sel_index;
    logic [1:0]                 w_sel_kind;
    logic                       r_valid;
    logic [INDEX_BIT_WIDTH-1:0] r_index;
    logic [1:0]                 r_kind;
    logic                       r_overflow;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [DEBOUNCE_LENGTH_BIT_WIDTH-1:0] r_cnt;
        logic                                 r_stable;
        logic                                 w_raw;
        logic                                 w_flip;
        logic                                 w_rise;
        logic                                 w_fall;
        state_t                               r_state;
        state_t                               w_state_nxt;
        logic [TIMER_BIT_WIDTH-1:0]           r_timer;
        logic [TIMER_BIT_WIDTH-1:0]           w_timer_nxt;
        logic [TIMER_BIT_WIDTH-1:0]           w_timer_inc;
        logic                                 w_long_hit;
        logic                                 w_rep_hit;
        logic [3:0]                           w_ev;

        assign w_raw  = ~signals_n[g];
        assign w_flip = tick && (w_raw != r_stable)
                        && (32'(r_cnt) >= DEBOUNCE_LENGTH - 1);
        assign w_rise = w_flip && !r_stable;
        assign w_fall = w_flip && r_stable;

        // Timer saturates so a misconfigured threshold never wraps around.
        assign w_timer_inc = (&r_timer) ? r_timer : r_timer + 1'b1;
        assign w_long_hit  = (32'(r_timer) == LONGPRESS_LENGTH - 1);
        assign w_rep_hit   = (32'(r_timer) == REPEAT_PERIOD - 1);

        // Debounce: accept a change only after DEBOUNCE_LENGTH differing ticks.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (tick) begin
                if (w_raw == r_stable) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_stable <= w_raw;
                    r_cnt    <= '0;
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Key state and hold timer registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_timer <= w_timer_nxt;
            end
        end

        // Next state and event generation; a release beats a timer threshold.
        always_comb begin
            w_state_nxt = r_state;
            w_timer_nxt = r_timer;
            w_ev        = '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt   = ST_HELD;
                        w_timer_nxt   = '0;
                        w_ev[K_PRESS] = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        w_state_nxt     = ST_IDLE;
                        w_timer_nxt     = '0;
                        w_ev[K_RELEASE] = 1'b1;
                    end else if (tick) begin
                        if (w_long_hit) begin
                            w_state_nxt  = ST_REPEATING;
                            w_timer_nxt  = '0;
                            w_ev[K_LONG] = 1'b1;
                        end else begin
                            w_timer_nxt = w_timer_inc;
                        end
                    end
                end
                ST_REPEATING: begin
                    if (w_fall) begin
                        w_state_nxt     = ST_IDLE;
                        w_timer_nxt     = '0;
                        w_ev[K_RELEASE] = 1'b1;
                    end else if (tick) begin
                        if (w_rep_hit) begin
                            w_timer_nxt    = '0;
                            w_ev[K_REPEAT] = 1'b1;
                        end else begin
                            w_timer_nxt = w_timer_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end

        assign w_set[g]   = w_ev;
        assign pressed[g] = r_stable;
    end

    // Fixed-priority pick: scan high to low so the lowest channel wins.
    always_comb begin
        w_any       = 1'b0;
        w_grant     = '0;
        w_sel_index = '0;
        w_sel_kind  = 2'd0;
        for (int c = N - 1; c >= 0; c--) begin
            for (int p = 3; p >= 0; p--) begin
                if (r_pend[c][KIND_ORDER[p]]) begin
                    w_any                      = 1'b1;
                    w_grant                    = '0;
                    w_grant[c][KIND_ORDER[p]]  = 1'b1;
                    w_sel_index                = INDEX_BIT_WIDTH'(c);
                    w_sel_kind                 = KIND_ORDER[p];
                end
            end
        end
    end

    assign w_load = w_any && (!r_valid || event_ready);
    assign w_clr  = w_load ? w_grant : '0;

    // Pending flags: a new set wins over the clear of a loaded flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (|(w_set & r_pend & ~w_clr)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output event register; fields hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_index <= '0;
            r_kind  <= 2'd0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_index <= w_sel_index;
            r_kind  <= w_sel_kind;
        end else if (event_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign event_valid = r_valid;
    assign event_index = r_index;
    assign event_kind  = r_kind;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_key_event_vector.sv
// Testbench for key_event_vector: directed scenarios plus a randomized run
// checked against a per-channel tick-level event model.
module tb_key_event_vector;
    localparam int N  = 16;
    localparam int IW = 4;
    localparam int DL = 4;
    localparam int LP = 512;
    localparam int RP = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          event_ready;
    logic [N-1:0]  signals_n;
    logic [N-1:0]  pressed;
    logic          event_valid;
    logic [IW-1:0] event_index;
    logic [1:0]    event_kind;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    int obs_ch[$];
    int obs_kd[$];
    int exp_q[N][$];
    int m_run[N];
    bit m_st[N];
    int m_held[N];

    key_event_vector #(
        .SIGNAL_BIT_WIDTH(N),
        .INDEX_BIT_WIDTH(IW),
        .DEBOUNCE_LENGTH(DL),
        .DEBOUNCE_LENGTH_BIT_WIDTH(3),
        .LONGPRESS_LENGTH(LP),
        .REPEAT_PERIOD(RP),
        .TIMER_BIT_WIDTH(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .signals_n(signals_n),
        .pressed(pressed),
        .event_valid(event_valid),
        .event_index(event_index),
        .event_kind(event_kind),
        .event_ready(event_ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no finish, want finish before 20000 clks");
        $fatal(1);
    end

    // Log every accepted event; the transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!reset && event_valid && event_ready) begin
            obs_ch.push_back(int'(event_index));
            obs_kd.push_back(int'(event_kind));
        end
    end

    // Reference model: run-length debounce, hold-tick count since press.
    always @(posedge clk or posedge reset) begin
        bit raw;
        bit fl;
        if (reset) begin
            for (int c = 0; c < N; c++) begin
                m_run[c]  = 0;
                m_st[c]   = 1'b0;
                m_held[c] = 0;
            end
        end else if (tick) begin
            for (int c = 0; c < N; c++) begin
                raw = ~signals_n[c];
                fl  = 1'b0;
                if (raw != m_st[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DL) begin
                        fl        = 1'b1;
                        m_st[c]   = raw;
                        m_run[c]  = 0;
                        m_held[c] = 0;
                        exp_q[c].push_back(raw ? 0 : 1);
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (!fl && m_st[c]) begin
                    m_held[c]++;
                    if (m_held[c] == LP)
                        exp_q[c].push_back(2);
                    else if (m_held[c] > LP && ((m_held[c] - LP) % RP) == 0)
                        exp_q[c].push_back(3);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        obs_ch.delete();
        obs_kd.delete();
        for (int c = 0; c < N; c++) exp_q[c].delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick = 1'b0;
        event_ready = 1'b0;
        signals_n = '1;
        cyc(2);
        total++;
        if (pressed !== '0) begin
            bad++;
            $display("FAIL rst_pressed: got %h want 0", pressed);
        end
        total++;
        if (event_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid: got %b want 0", event_valid);
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL rst_overflow: got %b want 0", overflow);
        end
        total++;
        if (event_index !== '0 || event_kind !== 2'd0) begin
            bad++;
            $display("FAIL rst_fields: got idx=%0d kind=%0d want 0/0",
                     event_index, event_kind);
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_press_release();
        clear_logs();
        tick = 1'b1;
        event_ready = 1'b1;
        signals_n[3] = 1'b0;
        cyc(3);
        total++;
        if (pressed[3] !== 1'b0) begin
            bad++;
            $display("FAIL pr_early: got pressed3=%b want 0", pressed[3]);
        end
        cyc(1);
        total++;
        if (pressed[3] !== 1'b1 || event_valid !== 1'b0) begin
            bad++;
            $display("FAIL pr_accept: got pressed3=%b valid=%b want 1/0",
                     pressed[3], event_valid);
        end
        cyc(1);
        total++;
        if (event_valid !== 1'b1 || event_index !== 4'd3 || event_kind !== 2'd0) begin
            bad++;
            $display("FAIL pr_press_ev: got v=%b idx=%0d kind=%0d want 1/3/0",
                     event_valid, event_index, event_kind);
        end
        cyc(1);
        total++;
        if (event_valid !== 1'b0) begin
            bad++;
            $display("FAIL pr_one_clk: got valid=%b want 0", event_valid);
        end
        signals_n[3] = 1'b1;
        cyc(4);
        total++;
        if (pressed[3] !== 1'b0) begin
            bad++;
            $display("FAIL pr_rel_level: got pressed3=%b want 0", pressed[3]);
        end
        cyc(1);
        total++;
        if (event_valid !== 1'b1 || event_index !== 4'd3 || event_kind !== 2'd1) begin
            bad++;
            $display("FAIL pr_release_ev: got v=%b idx=%0d kind=%0d want 1/3/1",
                     event_valid, event_index, event_kind);
        end
        cyc(2);
    endtask

    task automatic test_glitch();
        logic [11:0] pat;
        clear_logs();
        pat = 12'b1111_0100_1100;
        for (int i = 0; i < 12; i++) begin
            signals_n[0] = pat[i];
            cyc(1);
            total++;
            if (pressed[0] !== 1'b0 || event_valid !== 1'b0) begin
                bad++;
                $display("FAIL glitch_step%0d: got pressed0=%b valid=%b want 0/0",
                         i, pressed[0], event_valid);
            end
        end
        signals_n[0] = 1'b1;
        cyc(6);
        total++;
        if (obs_ch.size() != 0) begin
            bad++;
            $display("FAIL glitch_events: got %0d events want 0", obs_ch.size());
        end
    endtask

    task automatic test_long_repeat();
        int ek[6];
        int w;
        ek = '{0, 2, 3, 3, 3, 1};
        clear_logs();
        event_ready = 1'b1;
        signals_n[5] = 1'b0;
        w = 0;
        do begin
            cyc(1);
            w++;
        end while (!pressed[5] && w < 10);
        total++;
        if (pressed[5] !== 1'b1) begin
            bad++;
            $display("FAIL lr_press: got pressed5=%b want 1", pressed[5]);
        end
        cyc(LP + 3 * RP + 10);
        signals_n[5] = 1'b1;
        cyc(10);
        total++;
        if (obs_ch.size() != 6) begin
            bad++;
            $display("FAIL lr_count: got %0d events want 6", obs_ch.size());
        end
        for (int i = 0; i < 6 && i < obs_ch.size(); i++) begin
            total++;
            if (obs_ch[i] != 5 || obs_kd[i] != ek[i]) begin
                bad++;
                $display("FAIL lr_ev%0d: got ch=%0d kind=%0d want ch=5 kind=%0d",
                         i, obs_ch[i], obs_kd[i], ek[i]);
            end
        end
    endtask

    task automatic test_stall();
        clear_logs();
        event_ready = 1'b0;
        signals_n[2] = 1'b0;
        signals_n[9] = 1'b0;
        cyc(4);
        total++;
        if (pressed[2] !== 1'b1 || pressed[9] !== 1'b1) begin
            bad++;
            $display("FAIL st_pressed: got p2=%b p9=%b want 1/1", pressed[2], pressed[9]);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            total++;
            if (event_valid !== 1'b1 || event_index !== 4'd2 || event_kind !== 2'd0) begin
                bad++;
                $display("FAIL st_hold%0d: got v=%b idx=%0d kind=%0d want 1/2/0",
                         i, event_valid, event_index, event_kind);
            end
        end
        event_ready = 1'b1;
        cyc(1);
        total++;
        if (event_valid !== 1'b1 || event_index !== 4'd9 || event_kind !== 2'd0) begin
            bad++;
            $display("FAIL st_second: got v=%b idx=%0d kind=%0d want 1/9/0",
                     event_valid, event_index, event_kind);
        end
        cyc(1);
        total++;
        if (obs_ch.size() != 2 || obs_ch[0] != 2 || obs_ch[1] != 9) begin
            bad++;
            $display("FAIL st_order: got n=%0d first=%0d want n=2 order 2,9",
                     obs_ch.size(), obs_ch.size() > 0 ? obs_ch[0] : -1);
        end
        signals_n[2] = 1'b1;
        signals_n[9] = 1'b1;
        cyc(8);
        total++;
        if (obs_ch.size() != 4 || obs_ch[2] != 2 || obs_kd[2] != 1
            || obs_ch[3] != 9 || obs_kd[3] != 1) begin
            bad++;
            $display("FAIL st_release: got n=%0d want 4 with releases 2 then 9",
                     obs_ch.size());
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        event_ready = 1'b0;
        signals_n[0] = 1'b0;
        cyc(5);
        total++;
        if (event_valid !== 1'b1 || event_index !== 4'd0) begin
            bad++;
            $display("FAIL ov_occupy: got v=%b idx=%0d want 1/0", event_valid, event_index);
        end
        signals_n[1] = 1'b0;
        cyc(5);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ov_early: got %b want 0", overflow);
        end
        signals_n[1] = 1'b1;
        cyc(5);
        signals_n[1] = 1'b0;
        cyc(5);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ov_set: got %b want 1", overflow);
        end
        cyc(5);
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ov_sticky: got %b want 1", overflow);
        end
        signals_n = '1;
        signals_n[1] = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (overflow !== 1'b0 || event_valid !== 1'b0 || pressed !== '0) begin
            bad++;
            $display("FAIL ov_async_rst: got ovf=%b v=%b pressed=%h want 0/0/0",
                     overflow, event_valid, pressed);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        event_ready = 1'b1;
        clear_logs();
        cyc(3);
        total++;
        if (pressed[1] !== 1'b0) begin
            bad++;
            $display("FAIL ov_rehold_early: got pressed1=%b want 0", pressed[1]);
        end
        cyc(1);
        total++;
        if (pressed[1] !== 1'b1) begin
            bad++;
            $display("FAIL ov_rehold: got pressed1=%b want 1", pressed[1]);
        end
        cyc(1);
        total++;
        if (event_valid !== 1'b1 || event_index !== 4'd1 || event_kind !== 2'd0) begin
            bad++;
            $display("FAIL ov_fresh_press: got v=%b idx=%0d kind=%0d want 1/1/0",
                     event_valid, event_index, event_kind);
        end
        signals_n[1] = 1'b1;
        cyc(8);
    endtask

    task automatic test_threshold();
        int ks[3];
        int w;
        int n_exp;
        int ek[3];
        ks = '{LP - 1, LP, LP + 1};
        for (int t = 0; t < 3; t++) begin
            clear_logs();
            event_ready = 1'b1;
            signals_n = '1;
            signals_n[7] = 1'b0;
            w = 0;
            do begin
                cyc(1);
                w++;
            end while (!pressed[7] && w < 10);
            total++;
            if (pressed[7] !== 1'b1) begin
                bad++;
                $display("FAIL th_press_k%0d: got pressed7=%b want 1", ks[t], pressed[7]);
            end
            cyc(ks[t] - DL);
            signals_n[7] = 1'b1;
            cyc(10);
            if (ks[t] > LP) begin
                n_exp = 3;
                ek = '{0, 2, 1};
            end else begin
                n_exp = 2;
                ek = '{0, 1, 0};
            end
            total++;
            if (obs_ch.size() != n_exp) begin
                bad++;
                $display("FAIL th_count_k%0d: got %0d events want %0d",
                         ks[t], obs_ch.size(), n_exp);
            end
            for (int i = 0; i < n_exp && i < obs_ch.size(); i++) begin
                total++;
                if (obs_ch[i] != 7 || obs_kd[i] != ek[i]) begin
                    bad++;
                    $display("FAIL th_ev_k%0d_%0d: got ch=%0d kind=%0d want ch=7 kind=%0d",
                             ks[t], i, obs_ch[i], obs_kd[i], ek[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] e;
        int           ek;
        clear_logs();
        signals_n = '1;
        for (int i = 0; i < 3000; i++) begin
            tick = ($urandom_range(0, 3) != 0);
            event_ready = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 15) == 0) signals_n[c] = ~signals_n[c];
            end
            cyc(1);
            for (int c = 0; c < N; c++) e[c] = m_st[c];
            total++;
            if (pressed !== e) begin
                bad++;
                $display("FAIL rnd_pressed@%0d: got %h want %h", i, pressed, e);
            end
        end
        tick = 1'b1;
        event_ready = 1'b1;
        cyc(30);
        for (int i = 0; i < obs_ch.size(); i++) begin
            total++;
            if (exp_q[obs_ch[i]].size() == 0) begin
                bad++;
                $display("FAIL rnd_extra%0d: got ch=%0d kind=%0d want no event",
                         i, obs_ch[i], obs_kd[i]);
            end else begin
                ek = exp_q[obs_ch[i]].pop_front();
                if (obs_kd[i] != ek) begin
                    bad++;
                    $display("FAIL rnd_kind%0d: got ch=%0d kind=%0d want kind=%0d",
                             i, obs_ch[i], obs_kd[i], ek);
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            total++;
            if (exp_q[c].size() != 0) begin
                bad++;
                $display("FAIL rnd_missing_ch%0d: got %0d unsent want 0",
                         c, exp_q[c].size());
            end
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL rnd_overflow: got %b want 0", overflow);
        end
        signals_n = '1;
        cyc(12);
    endtask

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        event_ready = 1'b0;
        signals_n = '1;
        test_reset();
        test_press_release();
        test_glitch();
        test_long_repeat();
        test_stall();
        test_overflow();
        test_threshold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
